// File: rtl/spi_arbiter.sv
// spi_arbiter: two requesters share one SPI mode-0 master (8 bits, MSB first).
// Ties go to requester 0; defining SPI_ARB_ROUND_ROBIN_EN makes ties alternate instead.
module spi_arbiter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [3:0] half;
  logic [7:0] tx;
  logic [7:0] rx;
  logic       owner;
  logic       half_end;
  logic       win;
  logic [7:0] wsel;

  assign half_end = (cnt == LAST);
  assign busy     = (state != IDLE);
  assign MOSI     = tx[7];
  assign wsel     = gnt1 ? wdata1 : wdata0;

`ifdef SPI_ARB_ROUND_ROBIN_EN
  // last = 1 means requester 1 was served most recently, so a tie goes to 0
  logic last;

  always_ff @(posedge clk) begin
    if (btn_reset)
      last <= 1'b1;
    else if (gnt0 || gnt1)
      last <= gnt1;
  end

  assign win = (req0 && req1) ? ~last : req1;
`else
  assign win = req1 && !req0;
`endif

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (!btn_reset && (req0 || req1)) begin
          gnt0      = !win;
          gnt1      = win;
          state_nxt = SETUP;
        end
      end
      SETUP:   if (half_end) state_nxt = XFER;
      XFER:    if (half_end && half == 4'd15) state_nxt = HOLD;
      HOLD:    if (half_end) state_nxt = GAP;
      GAP:     if (half_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (btn_reset) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      half   <= 4'd0;
      tx     <= 8'd0;
      rx     <= 8'd0;
      owner  <= 1'b0;
      SCLK   <= 1'b0;
      SS     <= 1'b1;
      done0  <= 1'b0;
      done1  <= 1'b0;
      rdata0 <= 8'd0;
      rdata1 <= 8'd0;
    end else begin
      state <= state_nxt;
      done0 <= 1'b0;
      done1 <= 1'b0;
      cnt   <= (state == IDLE || half_end) ? 8'd0 : cnt + 8'd1;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            owner <= gnt1;
            tx    <= wsel;
            SS    <= 1'b0;
            SCLK  <= 1'b0;
            half  <= 4'd0;
          end
        end
        SETUP: begin
          if (half_end) begin
            SCLK <= 1'b1;
            rx   <= {rx[6:0], MISO};
          end
        end
        XFER: begin
          // half 15 ends low and stays low into HOLD; the 8th falling edge (end of half 14) keeps the last bit
          if (half_end && half != 4'd15) begin
            half <= half + 4'd1;
            SCLK <= ~SCLK;
            if (!SCLK)
              rx <= {rx[6:0], MISO};
            else if (half != 4'd14)
              tx <= {tx[6:0], 1'b0};
          end
        end
        HOLD: begin
          if (half_end) begin
            done0 <= !owner;
            done1 <= owner;
            if (owner)
              rdata1 <= rx;
            else
              rdata0 <= rx;
            SS <= 1'b1;
            tx <= 8'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Scoreboard bench: transaction-level model predicts grants/completions, a monitor checks them, a slave model drives MISO.
module tb_spi_arbiter;

  localparam int D = 4;
`ifdef SPI_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0, req1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, done0, done1, sclk, mosi, ss, busy;
  logic       miso = 1'b0;
  logic [7:0] rdata0, rdata1;

  logic       req0_b = 1'b0, req1_b = 1'b0, miso_b = 1'b0;
  logic [7:0] wdata0_b = 8'd0, wdata1_b = 8'd0;
  logic       gnt0_b, gnt1_b, done0_b, done1_b, sclk_b, mosi_b, ss_b, busy_b;
  logic [7:0] rdata0_b, rdata1_b;

  spi_arbiter #(.CLK_DIV(D)) u_dut (
    .clk(clk), .btn_reset(rst), .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .SCLK(sclk), .MOSI(mosi), .MISO(miso), .SS(ss), .busy(busy));

  spi_arbiter #(.CLK_DIV(1)) u_dut_b (
    .clk(clk), .btn_reset(rst), .req0(req0_b), .req1(req1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .SCLK(sclk_b), .MOSI(mosi_b), .MISO(miso_b), .SS(ss_b), .busy(busy_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out, expected event never seen (cycle %0d)", name, cyc);
  endtask

  // requester agents: req stays up until the DUT has granted every posted request
  int add0 = 0, add1 = 0, served0 = 0, served1 = 0;
  assign req0 = (add0 != served0);
  assign req1 = (add1 != served1);
  bit g0s, g1s;
  always begin
    @(negedge clk);
    g0s = (gnt0 === 1'b1);
    g1s = (gnt1 === 1'b1);
    @(posedge clk);
    #1;
    if (g0s) served0++;
    if (g1s) served1++;
  end

  // reference model: a transfer granted at T completes at T+1+18D and frees the bus at T+1+19D
  typedef struct {
    int         id;
    logic [7:0] s;
    int         done_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] slave_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] m_rdata[2];
  int         glog_id[$];
  int         glog_cyc[$];
  bit         mdl_on = 1'b0;
  bit         rst_prev = 1'b0;
  bit         last_id = 1'b1;
  int         free_cyc = 0;
  int         grant_cyc = -1000;
  logic       fix_s_vld = 1'b0;
  logic [7:0] fix_s = 8'd0;
  logic       rand_w = 1'b1;

  always @(negedge clk) begin
    if (mdl_on) begin
      bit   eg0, eg1, eb;
      int   id;
      exp_t e;
      eb  = (cyc > grant_cyc) && (cyc < free_cyc);
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (rst_prev) begin
        exp_q.delete();
        m_rdata[0] = 8'd0;
        m_rdata[1] = 8'd0;
        last_id = 1'b1;
        check("rst_ss", ss, 1);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
      end
      if (rst) begin
        if (free_cyc > cyc + 1) free_cyc = cyc + 1;
      end else if (cyc >= free_cyc && (req0 || req1)) begin
        if (req0 && req1) id = RR ? int'(!last_id) : 0;
        else id = req1 ? 1 : 0;
        e.id = id;
        e.s = fix_s_vld ? fix_s : 8'($urandom);
        e.done_cyc = cyc + 1 + 18 * D;
        exp_q.push_back(e);
        slave_q.push_back(e.s);
        mosi_q.push_back(id == 1 ? wdata1 : wdata0);
        eg0 = (id == 0);
        eg1 = (id == 1);
        grant_cyc = cyc;
        free_cyc = cyc + 1 + 19 * D;
        last_id = (id == 1);
      end
      check("gnt0", gnt0, eg0);
      check("gnt1", gnt1, eg1);
      check("busy", busy, eb);
      rst_prev = rst;
    end
  end

  // monitor: every done pulse pops the oldest outstanding transfer
  always @(negedge clk) begin
    if (mdl_on) begin
      exp_t e;
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        glog_id.push_back(gnt1 === 1'b1 ? 1 : 0);
        glog_cyc.push_back(cyc);
      end
      if (done0 === 1'b1 || done1 === 1'b1) begin
        check("one_done", done0 && done1, 0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL done_unexpected: done pulse with no outstanding transfer (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_owner", done1 ? 1 : 0, e.id);
          check("done_cycle", cyc, e.done_cyc);
          m_rdata[e.id] = e.s;
          check("rdata0", rdata0, m_rdata[0]);
          check("rdata1", rdata1, m_rdata[1]);
        end
      end
    end
  end

  // SPI slave: MISO from the queued byte, updated after falling edges; MOSI collected on rising edges
  logic       ss_p = 1'b1, sclk_p = 1'b0;
  logic [7:0] shreg = 8'd0, mbits = 8'd0, wexp;
  int         rises = 0;
  always @(negedge clk) begin
    if (mdl_on) begin
      if (ss_p && !ss) begin
        shreg = (slave_q.size() > 0) ? slave_q.pop_front() : 8'd0;
        miso  = shreg[7];
        rises = 0;
        mbits = 8'd0;
      end
      if (!ss && !sclk_p && sclk) begin
        mbits = {mbits[6:0], mosi};
        rises++;
      end
      if (!ss && sclk_p && !sclk) begin
        shreg = {shreg[6:0], 1'b0};
        miso  = shreg[7];
      end
      if (!ss_p && ss) begin
        wexp = (mosi_q.size() > 0) ? mosi_q.pop_front() : 8'hxx;
        if (rises == 8) check("mosi_byte", mbits, wexp);
      end
      ss_p = ss;
      sclk_p = sclk;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_w) begin
        wdata0 = 8'($urandom);
        wdata1 = 8'($urandom);
      end
    end
  endtask

  task automatic wait_gnts(input int n0, input int cnt);
    int k = 0;
    while (glog_id.size() < n0 + cnt && k < 1000) begin
      tick(1);
      k++;
    end
    if (glog_id.size() < n0 + cnt) timeout("wait_grant");
  endtask

  task automatic drain();
    int k = 0;
    while (!(busy === 1'b0 && exp_q.size() == 0 && add0 == served0 && add1 == served1) && k < 12000) begin
      tick(1);
      k++;
    end
    if (k >= 12000) timeout("drain");
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // CLK_DIV=1 instance: one transfer from requester 1 with a constant MISO level
  task automatic run_b(input logic mv, input logic [7:0] exp_r);
    int   t = -1, k = 0, tog = 0, first_t = -1, last_t = -1, done_at = -1, d0 = 0;
    logic prev;
    miso_b = mv;
    wdata1_b = 8'hFF;
    req1_b = 1'b1;
    while (k < 50 && t < 0) begin
      @(negedge clk);
      if (gnt1_b === 1'b1) t = cyc;
      k++;
    end
    if (t < 0) begin
      timeout("b_grant");
      req1_b = 1'b0;
      return;
    end
    check("b_gnt0", gnt0_b, 0);
    prev = sclk_b;
    @(posedge clk);
    #1;
    req1_b = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (i == 1) check("b_mosi_msb", mosi_b, 1);
      if (sclk_b !== prev) begin
        tog++;
        if (first_t < 0) first_t = cyc;
        last_t = cyc;
      end
      prev = sclk_b;
      if (done1_b === 1'b1 && done_at < 0) done_at = cyc;
      if (done0_b !== 1'b0) d0++;
    end
    check("b_toggles", tog, 16);
    check("b_first_toggle", first_t, t + 2);
    check("b_last_toggle", last_t, t + 17);
    check("b_done_cycle", done_at, t + 19);
    check("b_rdata1", rdata1_b, exp_r);
    check("b_rdata0", rdata0_b, 0);
    check("b_done0_quiet", d0, 0);
    check("b_ss_idle", ss_b, 1);
    check("b_busy_idle", busy_b, 0);
  endtask

  initial begin
    int n, t;
    rst = 1'b1;
    wdata0 = 8'd0;
    wdata1 = 8'd0;
    tick(2);
    mdl_on = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(3);

    // single transfer: 0xA5 out on requester 0, slave answers 0x3C
    rand_w = 1'b0;
    wdata0 = 8'hA5;
    fix_s_vld = 1'b1;
    fix_s = 8'h3C;
    n = glog_id.size();
    add0++;
    wait_gnts(n, 1);
    drain();
    check("a5_rdata0", rdata0, 8'h3C);
    check("a5_rdata1", rdata1, 8'h00);
    fix_s_vld = 1'b0;
    rand_w = 1'b1;

    // both requesters held for several transfers right after reset
    pulse_reset();
    tick(2);
    n = glog_id.size();
    add0 += 3;
    add1 += 3;
    wait_gnts(n, 3);
    if (glog_id.size() >= n + 3) begin
      check("tie_first", glog_id[n], 0);
      check("tie_second", glog_id[n+1], RR ? 1 : 0);
      check("tie_third", glog_id[n+2], 0);
    end
    drain();

    // requester 0 arriving mid-transfer waits for the first IDLE cycle
    n = glog_id.size();
    add1++;
    wait_gnts(n, 1);
    t = (glog_cyc.size() > n) ? glog_cyc[n] : cyc;
    tick(20);
    add0++;
    wait_gnts(n, 2);
    if (glog_id.size() >= n + 2) begin
      check("late_req_id", glog_id[n+1], 0);
      check("late_req_cycle", glog_cyc[n+1], t + 1 + 19 * D);
    end
    drain();

    // reset 30 cycles into a transfer, then an immediate new request
    n = glog_id.size();
    add0++;
    wait_gnts(n, 1);
    t = (glog_cyc.size() > n) ? glog_cyc[n] : cyc;
    while (cyc < t + 30) tick(1);
    pulse_reset();
    add1++;
    wait_gnts(n, 2);
    if (glog_id.size() >= n + 2) check("post_rst_grant_cycle", glog_cyc[n+1], t + 31);
    drain();

    // random traffic with occasional resets
    repeat (30) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) add0++;
      else if (r < 7) add1++;
      else if (r < 9) begin
        add0++;
        add1++;
      end else pulse_reset();
      tick($urandom_range(1, 120));
    end
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    run_b(1'b1, 8'hFF);
    tick(2);
    run_b(1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
